// File: rtl/vga_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : vga_pkg
// Description : Shared constants for the 640x480@60 Hz raster path. Holds the
//               default horizontal/vertical timing values and the coordinate
//               widths used by the timing generator and the RLE pixel stage.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Coordinate widths shared with the RLE pixel stage and the top level.
  localparam int VGA_X_W = 11;
  localparam int VGA_Y_W = 10;

  // Default 640x480@60 Hz timing (25.175 MHz pixel clock).
  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  // Level driven on HSync/VSync during the pulse (0 = negative polarity).
  localparam logic VGA_SYNC_ACTIVE = 1'b0;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_axis_ctr.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : vga_axis_ctr
// Description : One raster axis. A 0..TOTAL-1 wrap counter that advances when
//               i_En is high, a wrap strobe for chaining the next axis, and a
//               registered range decode used to build a sync pulse.
// Revision    : 1.0 - initial release
//
// Ports:
//   i_Clk     in   1      pixel clock, rising edge
//   i_Rst_n   in   1      asynchronous active-low reset
//   i_En      in   1      count enable
//   o_Count   out  WIDTH  current counter value (flop output)
//   o_Wrap    out  1      high on the enabled cycle that returns the count to 0
//   o_Flag    out  1      registered: ACTIVE_LVL when RANGE_LO <= count < RANGE_HI
// ============================================================================
module vga_axis_ctr #(
  parameter int   WIDTH      = 11,
  parameter int   TOTAL      = 800,
  parameter int   RANGE_LO   = 656,
  parameter int   RANGE_HI   = 752,
  parameter logic ACTIVE_LVL = 1'b0
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_En,
  output logic [WIDTH-1:0] o_Count,
  output logic             o_Wrap,
  output logic             o_Flag
);

  localparam logic [WIDTH-1:0] c_LAST = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH-1:0] c_LO   = WIDTH'(RANGE_LO);
  localparam logic [WIDTH-1:0] c_HI   = WIDTH'(RANGE_HI);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             flag_q;
  logic             flag_d;
  logic             w_wrap;
  logic             w_in_range;

  always_comb begin
    w_wrap     = i_En && (count_q == c_LAST);
    count_d    = count_q;
    if (i_En) begin
      count_d = w_wrap ? '0 : count_q + WIDTH'(1);
    end
    // Decoded from the present count so the flag lines up with the
    // registered coordinate outputs of the top level.
    w_in_range = (count_q >= c_LO) && (count_q < c_HI);
    flag_d     = w_in_range ? ACTIVE_LVL : ~ACTIVE_LVL;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      count_q <= '0;
      flag_q  <= ~ACTIVE_LVL;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
    end
  end

  assign o_Count = count_q;
  assign o_Wrap  = w_wrap;
  assign o_Flag  = flag_q;

endmodule : vga_axis_ctr
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : vga_timing
// Description : Raster timing generator for the 640x480@60 Hz output path.
//               Produces HSync, VSync, data enable, pixel coordinates and a
//               frame-start pulse. Every output is a flop decoded from the
//               counter state of the previous cycle, so the first edge after
//               reset release presents position (0,0).
// Revision    : 1.0 - initial release
//
// Ports:
//   i_Clk         in   1   pixel clock, rising edge
//   i_Rst_n       in   1   asynchronous active-low reset
//   o_HSync       out  1   horizontal sync (SYNC_ACTIVE during pulse)
//   o_VSync       out  1   vertical sync (SYNC_ACTIVE during pulse)
//   o_DE          out  1   data enable, high for visible pixels
//   o_X           out  11  pixel column, free-running through blanking
//   o_Y           out  10  line number, free-running through blanking
//   o_FrameStart  out  1   one-cycle pulse at position (0,0)
//   o_Frame       out  8   frame counter (only with VGA_TIMING_FRAMECTR_EN)
//
// Build option:
//   VGA_TIMING_FRAMECTR_EN - adds o_Frame, an 8-bit wrapping frame counter
//                            that steps on the edge registering FrameStart.
//
// Constraint: H_TOTAL <= 2048 and V_TOTAL <= 1024 (11-bit / 10-bit counters).
// ============================================================================
module vga_timing
  import vga_pkg::*;
#(
  parameter int   H_VISIBLE   = VGA_H_VISIBLE,
  parameter int   H_FP        = VGA_H_FP,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BP        = VGA_H_BP,
  parameter int   V_VISIBLE   = VGA_V_VISIBLE,
  parameter int   V_FP        = VGA_V_FP,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BP        = VGA_V_BP,
  parameter logic SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  output logic               o_HSync,
  output logic               o_VSync,
  output logic               o_DE,
  output logic [VGA_X_W-1:0] o_X,
  output logic [VGA_Y_W-1:0] o_Y,
  output logic               o_FrameStart
`ifdef VGA_TIMING_FRAMECTR_EN
  ,
  output logic [7:0]         o_Frame
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [VGA_X_W-1:0] c_H_VIS = VGA_X_W'(H_VISIBLE);
  localparam logic [VGA_Y_W-1:0] c_V_VIS = VGA_Y_W'(V_VISIBLE);

  logic [VGA_X_W-1:0] w_h_count;
  logic [VGA_Y_W-1:0] w_v_count;
  logic               w_h_wrap;
  logic               w_v_wrap;

  logic               de_q;
  logic               de_d;
  logic [VGA_X_W-1:0] x_q;
  logic [VGA_X_W-1:0] x_d;
  logic [VGA_Y_W-1:0] y_q;
  logic [VGA_Y_W-1:0] y_d;
  logic               frame_start_q;
  logic               frame_start_d;
  logic               origin_q;
  logic               origin_d;

  // Horizontal axis: always counting; sync pulse over the H sync window.
  vga_axis_ctr #(
    .WIDTH      (VGA_X_W),
    .TOTAL      (H_TOTAL),
    .RANGE_LO   (H_VISIBLE + H_FP),
    .RANGE_HI   (H_VISIBLE + H_FP + H_SYNC),
    .ACTIVE_LVL (SYNC_ACTIVE)
  ) u_h_ctr (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_En    (1'b1),
    .o_Count (w_h_count),
    .o_Wrap  (w_h_wrap),
    .o_Flag  (o_HSync)
  );

  // Vertical axis: steps once per line. Its sync decode only changes when the
  // line changes, so VSync covers whole lines starting at h = 0.
  vga_axis_ctr #(
    .WIDTH      (VGA_Y_W),
    .TOTAL      (V_TOTAL),
    .RANGE_LO   (V_VISIBLE + V_FP),
    .RANGE_HI   (V_VISIBLE + V_FP + V_SYNC),
    .ACTIVE_LVL (SYNC_ACTIVE)
  ) u_v_ctr (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_En    (w_h_wrap),
    .o_Count (w_v_count),
    .o_Wrap  (w_v_wrap),
    .o_Flag  (o_VSync)
  );

  always_comb begin
    de_d          = (w_h_count < c_H_VIS) && (w_v_count < c_V_VIS);
    x_d           = w_h_count;
    y_d           = w_v_count;
    // origin_q marks "counters currently hold (0,0)": set by reset and by the
    // frame wrap strobe, which avoids a full-width compare of both counters.
    frame_start_d = origin_q;
    origin_d      = w_v_wrap;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      origin_q      <= 1'b1;
    end else begin
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      origin_q      <= origin_d;
    end
  end

  assign o_DE         = de_q;
  assign o_X          = x_q;
  assign o_Y          = y_q;
  assign o_FrameStart = frame_start_q;

`ifdef VGA_TIMING_FRAMECTR_EN
  logic [7:0] frame_q;
  logic [7:0] frame_d;

  // Steps on the same edge that registers FrameStart; wraps naturally 255->0.
  always_comb begin
    frame_d = frame_q + {7'd0, origin_q};
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      frame_q <= 8'd0;
    end else begin
      frame_q <= frame_d;
    end
  end

  assign o_Frame = frame_q;
`endif

endmodule : vga_timing
`default_nettype wire
